mac_acc_pipe: RTL and testbench

//  Parametrised, pipelined signed multiply-accumulate engine for CNN dot products.

---
 rtl/mac_acc_pipe.sv | 193 +++++++++++++++++++
 tb/tb_mac_acc_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_pipe.sv
// -----------------------------------------------------------------------------
// mac_acc_pipe
// Pipelined signed multiply-accumulate engine for CNN dot products.
// A packet of a*b beats, delimited by in_first / in_last, is summed onto a
// per-packet bias and one result is emitted per packet together with its
// term count and an overflow flag.
//
// Pipeline:
//   S1 : registers the full-width product and the beat side-band
//        (valid, first, last, bias).
//   S2 : adds the product to the running sum (or to the bias on a packet
//        start), saturates or wraps, and publishes the result on in_last.
//
// Ports:
//   clk        rising-edge clock
//   sclr       asynchronous, active-high reset
//   ce         clock enable; 0 freezes every register
//   in_valid   beat valid
//   in_first   first beat of packet (loads bias)
//   in_last    last beat of packet (emits result)
//   a, b       signed DATA_W operands
//   bias       signed ACC_W bias, used only with in_first
//   acc_out    signed ACC_W packet result
//   term_cnt   number of beats in the emitted packet (wraps modulo 2**CNT_W)
//   ovf        overflow in any beat of the emitted packet
//   out_valid  one ce-cycle result strobe
//   err        sticky protocol error, cleared only by sclr
//   busy       packet open or S1 holding a valid beat
// -----------------------------------------------------------------------------
module mac_acc_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 10,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     sclr,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [ACC_W-1:0]  bias,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic        [CNT_W-1:0]  term_cnt,
    output logic                     ovf,
    output logic                     out_valid,
    output logic                     err,
    output logic                     busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // Reduce an ACC_W+1 bit sum to ACC_W bits: clamp or wrap on overflow.
    function automatic logic signed [ACC_W-1:0] fit_acc(input logic [SUM_W-1:0] s);
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (SAT != 0) begin
                return s[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                return s[ACC_W-1:0];
            end
        end else begin
            return s[ACC_W-1:0];
        end
    endfunction

    // Stage 1 registers
    logic                     s1_v_r;
    logic                     s1_first_r;
    logic                     s1_last_r;
    logic signed [PROD_W-1:0] s1_prod_r;
    logic signed [ACC_W-1:0]  s1_bias_r;

    // Stage 2 state
    state_t                   state_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic        [CNT_W-1:0]  cnt_r;
    logic                     pkt_ovf_r;

    // Stage 2 combinational results
    state_t                   state_nxt_s;
    logic                     start_s;
    logic                     err_set_s;
    logic signed [ACC_W-1:0]  bias_sel_s;
    logic signed [ACC_W-1:0]  base_s;
    logic        [SUM_W-1:0]  sum_s;
    logic                     ovf_cond_s;
    logic signed [ACC_W-1:0]  acc_nxt_s;
    logic                     pkt_ovf_nxt_s;
    logic        [CNT_W-1:0]  cnt_nxt_s;

    // Stage 1: product and beat side-band capture.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            s1_v_r     <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_prod_r  <= '0;
            s1_bias_r  <= '0;
        end else if (ce) begin
            s1_v_r     <= in_valid;
            s1_first_r <= in_first;
            s1_last_r  <= in_last;
            s1_prod_r  <= PROD_W'(a) * PROD_W'(b);
            s1_bias_r  <= bias;
        end
    end

    // Stage 2: packet FSM decode, protocol checks and the saturating add.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        err_set_s   = 1'b0;
        if (s1_v_r) begin
            case (state_r)
                ST_IDLE: begin
                    // A headless beat is treated as a packet start with bias 0.
                    start_s   = 1'b1;
                    err_set_s = ~s1_first_r;
                end
                ST_ACC: begin
                    // A first inside an open packet drops the old sum.
                    start_s   = s1_first_r;
                    err_set_s = s1_first_r;
                end
                default: begin
                    start_s   = 1'b1;
                    err_set_s = 1'b1;
                end
            endcase
            state_nxt_s = s1_last_r ? ST_IDLE : ST_ACC;
        end else begin
            state_nxt_s = state_r;
        end

        bias_sel_s    = s1_first_r ? s1_bias_r : '0;
        base_s        = start_s ? bias_sel_s : acc_r;
        // One guard bit makes the overflow test a simple top-two-bit compare.
        sum_s         = {base_s[ACC_W-1], base_s}
                      + {{(SUM_W-PROD_W){s1_prod_r[PROD_W-1]}}, s1_prod_r};
        ovf_cond_s    = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        acc_nxt_s     = fit_acc(sum_s);
        pkt_ovf_nxt_s = (start_s ? 1'b0 : pkt_ovf_r) | ovf_cond_s;
        cnt_nxt_s     = start_s ? CNT_W'(1) : (cnt_r + CNT_W'(1));
    end

    // Stage 2: accumulator, FSM state and registered outputs.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            state_r   <= ST_IDLE;
            acc_r     <= '0;
            cnt_r     <= '0;
            pkt_ovf_r <= 1'b0;
            acc_out   <= '0;
            term_cnt  <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else if (ce) begin
            state_r <= state_nxt_s;
            // Registered form of "packet open or stage 1 valid" after this edge.
            busy    <= (state_nxt_s == ST_ACC) | in_valid;
            if (s1_v_r) begin
                acc_r     <= acc_nxt_s;
                cnt_r     <= cnt_nxt_s;
                pkt_ovf_r <= pkt_ovf_nxt_s;
                err       <= err | err_set_s;
                if (s1_last_r) begin
                    acc_out   <= acc_nxt_s;
                    term_cnt  <= cnt_nxt_s;
                    ovf       <= pkt_ovf_nxt_s;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// -----------------------------------------------------------------------------
// tb_mac_acc_pipe
// Drives a saturating and a wrapping instance (DATA_W=8, ACC_W=16) with the
// same beats and compares both against a packet-level reference model that
// uses plain integer arithmetic. Directed packets check the documented
// example values as constants; a randomized phase covers the rest.
// -----------------------------------------------------------------------------
module tb_mac_acc_pipe;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int CW = 10;

    localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (AW - 1));
    localparam longint MODV = longint'(1) << AW;

    logic                 clk = 1'b0;
    logic                 sclr, ce, in_valid, in_first, in_last;
    logic signed [DW-1:0] a, b;
    logic signed [AW-1:0] bias;

    logic signed [AW-1:0] acc_out0, acc_out1;
    logic        [CW-1:0] term_cnt0, term_cnt1;
    logic                 ovf0, ovf1, out_valid0, out_valid1;
    logic                 err0, err1, busy0, busy1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: packet view plus the beat waiting in the multiplier.
    bit     p_v, p_f, p_l;
    longint p_a, p_b, p_bias;
    bit     m_open, m_err, e_valid;
    longint m_acc [2];
    bit     m_povf [2];
    longint e_out [2];
    bit     e_ovf [2];
    int     m_cnt, e_tc;

    mac_acc_pipe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .SAT(1)) dut_sat (
        .clk(clk), .sclr(sclr), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .a(a), .b(b), .bias(bias), .acc_out(acc_out0),
        .term_cnt(term_cnt0), .ovf(ovf0), .out_valid(out_valid0), .err(err0), .busy(busy0)
    );

    mac_acc_pipe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .SAT(0)) dut_wrap (
        .clk(clk), .sclr(sclr), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .a(a), .b(b), .bias(bias), .acc_out(acc_out1),
        .term_cnt(term_cnt1), .ovf(ovf1), .out_valid(out_valid1), .err(err1), .busy(busy1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        p_v = 1'b0; p_f = 1'b0; p_l = 1'b0; p_a = 0; p_b = 0; p_bias = 0;
        m_open = 1'b0; m_err = 1'b0; e_valid = 1'b0; m_cnt = 0; e_tc = 0;
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_povf[k] = 1'b0; e_out[k] = 0; e_ovf[k] = 1'b0;
        end
    endtask

    // One enabled clock edge: finish the waiting beat, then accept the new one.
    task automatic model_edge(input bit v, input bit f, input bit l,
                              input longint aa, input longint bb, input longint bi);
        bit     start, ov;
        longint base, sum, res;
        if (p_v) begin
            start = m_open ? p_f : 1'b1;
            if (m_open == p_f) m_err = 1'b1;
            for (int k = 0; k < 2; k++) begin
                base = start ? (p_f ? p_bias : 0) : m_acc[k];
                sum  = base + p_a * p_b;
                ov   = (sum > MAXV) || (sum < MINV);
                res  = sum;
                if (ov && k == 0) res = (sum > MAXV) ? MAXV : MINV;
                if (ov && k == 1) begin
                    res = sum & (MODV - 1);
                    if (res > MAXV) res = res - MODV;
                end
                m_acc[k]  = res;
                m_povf[k] = (start ? 1'b0 : m_povf[k]) | ov;
                if (p_l) begin
                    e_out[k] = res;
                    e_ovf[k] = m_povf[k];
                end
            end
            m_cnt = start ? 1 : (m_cnt + 1) % (1 << CW);
            if (p_l) e_tc = m_cnt;
            e_valid = p_l;
            m_open  = !p_l;
        end else begin
            e_valid = 1'b0;
        end
        p_v = v; p_f = f; p_l = l; p_a = aa; p_b = bb; p_bias = bi;
    endtask

    task automatic compare_all();
        chk("acc_out_sat",  acc_out0,   e_out[0]);
        chk("acc_out_wrap", acc_out1,   e_out[1]);
        chk("ovf_sat",      ovf0,       e_ovf[0]);
        chk("ovf_wrap",     ovf1,       e_ovf[1]);
        chk("term_cnt",     term_cnt0,  e_tc);
        chk("term_cnt_w",   term_cnt1,  e_tc);
        chk("out_valid",    out_valid0, e_valid);
        chk("out_valid_w",  out_valid1, e_valid);
        chk("err",          err0,       m_err);
        chk("err_w",        err1,       m_err);
        chk("busy",         busy0,      m_open | p_v);
        chk("busy_w",       busy1,      m_open | p_v);
    endtask

    // One clock cycle: drive on the falling edge, check just after the rising edge.
    task automatic step(input bit c, input bit s, input bit v, input bit f, input bit l,
                        input longint aa, input longint bb, input longint bi);
        @(negedge clk);
        ce = c; sclr = s; in_valid = v; in_first = f; in_last = l;
        a = DW'(aa); b = DW'(bb); bias = AW'(bi);
        if (s) model_reset();
        @(posedge clk);
        #1;
        if (!s && c) model_edge(v, f, l, aa, bb, bi);
        compare_all();
    endtask

    task automatic beat(input bit f, input bit l, input longint aa, input longint bb, input longint bi);
        step(1'b1, 1'b0, 1'b1, f, l, aa, bb, bi);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Run idle cycles until a result appears (bounded) and check it.
    task automatic wait_out(input string tag, input int exp_lat, input longint exp_sat,
                            input longint exp_wrap, input int exp_cnt, input bit exp_ovf);
        int n = 0;
        while (out_valid0 !== 1'b1 && n < 8) begin
            idle();
            n++;
        end
        chk({tag, "_lat"},      n,        exp_lat);
        chk({tag, "_acc_sat"},  acc_out0, exp_sat);
        chk({tag, "_acc_wrap"}, acc_out1, exp_wrap);
        chk({tag, "_cnt"},      term_cnt0, exp_cnt);
        chk({tag, "_ovf"},      ovf0,     exp_ovf);
    endtask

    task automatic pkt_basic();
        beat(1'b1, 1'b0, 3, 4, 5);
        beat(1'b0, 1'b0, -2, 7, 0);
        beat(1'b0, 1'b1, 0, 9, 0);
    endtask

    initial begin
        model_reset();
        sclr = 1'b1; ce = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        a = '0; b = '0; bias = '0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("rst_acc_out", acc_out0, 0);
        chk("rst_valid",   out_valid0, 0);
        chk("rst_busy",    busy0, 0);
        chk("rst_err",     err0, 0);
        idle();

        // Basic packet: 5 + 12 - 14 + 0 = 3, one-cycle strobe.
        pkt_basic();
        wait_out("t1", 1, 3, 3, 3, 1'b0);
        idle();
        chk("t1_pulse_end", out_valid0, 0);

        // Overflow: 32700 + 16129.
        beat(1'b1, 1'b1, 127, 127, 32700);
        wait_out("t2", 1, 32767, -16707, 1, 1'b1);
        chk("t2_ovf_wrap", ovf1, 1);

        // Back-to-back single-beat packets.
        beat(1'b1, 1'b1, -128, -128, 0);
        beat(1'b1, 1'b1, 1, 1, -1);
        wait_out("t3a", 0, 16384, 16384, 1, 1'b0);
        idle();
        chk("t3b_valid", out_valid0, 1);
        chk("t3b_acc",   acc_out0, 0);

        // Clock-enable freeze mid-packet; garbage inputs must be ignored.
        beat(1'b1, 1'b0, 3, 4, 5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 100, 100, 1000);
        beat(1'b0, 1'b0, -2, 7, 0);
        beat(1'b0, 1'b1, 0, 9, 0);
        wait_out("t4", 1, 3, 3, 3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("t4_valid_held", out_valid0, 1);
        idle();

        // Reset mid-packet.
        beat(1'b1, 1'b0, 3, 4, 5);
        beat(1'b0, 1'b0, -2, 7, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("t5_acc_out", acc_out0, 0);
        chk("t5_busy",    busy0, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t5_no_valid", out_valid0, 0);
        end
        pkt_basic();
        wait_out("t5", 1, 3, 3, 3, 1'b0);

        // Headless packet, then a re-open inside a packet.
        beat(1'b0, 1'b0, 2, 3, 99);
        beat(1'b0, 1'b1, 1, 1, 0);
        wait_out("t6", 1, 7, 7, 2, 1'b0);
        chk("t6_err", err0, 1);
        beat(1'b1, 1'b0, 1, 2, 0);
        beat(1'b0, 1'b0, 1, 1, 0);
        beat(1'b1, 1'b0, 2, 2, 10);
        beat(1'b0, 1'b1, 1, 1, 0);
        wait_out("t6b", 1, 15, 15, 2, 1'b0);
        chk("t6b_err_sticky", err0, 1);

        // Randomized traffic with bubbles, ce gaps and occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 5) != 0, ($urandom % 60) == 0, ($urandom % 4) != 0,
                 ($urandom % 4) == 0, ($urandom % 4) == 0,
                 longint'($urandom_range(0, 255)) - 128,
                 longint'($urandom_range(0, 255)) - 128,
                 longint'($urandom_range(0, 65535)) - 32768);
        end
        for (int i = 0; i < 4; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
